// File: rtl/ngmux_pkg.sv
// ============================================================================
// Module      : ngmux_pkg
// Description : Shared types and constants for the glitchless clock-mux
//               switch sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ngmux_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SWITCH = 2'd2,
    SETTLE = 2'd3
  } ngmux_state_e;

  localparam logic CLKSEL_REF = 1'b0;
  localparam logic CLKSEL_PLL = 1'b1;

  // Width able to hold the largest of the three cycle counts.
  function automatic int ngmux_cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/ngmux_lock_qual.sv
// ============================================================================
// Module      : ngmux_lock_qual
// Description : Synchronises the asynchronous PLL lock and qualifies it as
//               stable after LOCK_STABLE_CYCLES consecutive high samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ngmux_lock_qual
  import ngmux_pkg::*;
#(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 64
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_pll_lock,
  output logic o_lock_ok
);

  localparam int LW = ngmux_cnt_width(LOCK_STABLE_CYCLES, 1, 1);
  localparam logic [LW-1:0] c_lock_max = LW'(LOCK_STABLE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [LW-1:0]          r_cnt;
  logic                   w_synced;

  assign w_synced = r_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_sync <= '0;
      r_cnt  <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pll_lock};
      if (!w_synced) begin
        r_cnt <= '0;
      end else if (r_cnt != c_lock_max) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Gated by the live synced sample so a single low drops lock_ok at once.
  assign o_lock_ok = w_synced && (r_cnt == c_lock_max);

endmodule

`default_nettype wire

// File: rtl/ngmux_switch_ctrl.sv
// ============================================================================
// Module      : ngmux_switch_ctrl
// Description : Sequencer for a glitchless clock mux: drains the core, drives
//               the mux select, waits for settling, and falls back to the
//               reference clock when the PLL loses lock.
//               Optional drain timeout: define NGMUX_DRAIN_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ngmux_switch_ctrl
  import ngmux_pkg::*;
#(
  parameter int SETTLE_CYCLES      = 16,
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 64,
  parameter int TIMEOUT_CYCLES     = 1024
) (
  input  logic i_clk,
  input  logic i_resetn,
  input  logic i_req_valid,
  input  logic i_req_sel,
  output logic o_req_ready,
  input  logic i_core_busy,
  output logic o_core_hold,
  input  logic i_pll_lock,
  output logic o_sel,
  output logic o_cur_sel,
  output logic o_switch_done,
  output logic o_fallback,
  output logic o_err
);

  localparam int CW = ngmux_cnt_width(SETTLE_CYCLES, LOCK_STABLE_CYCLES, TIMEOUT_CYCLES);
  localparam logic [CW-1:0] c_settle_ld = CW'(SETTLE_CYCLES - 1);
`ifdef NGMUX_DRAIN_TIMEOUT_EN
  localparam logic [CW-1:0] c_tmo_last = CW'(TIMEOUT_CYCLES - 1);
`endif

  ngmux_state_e r_state, w_state_nxt;
  logic          r_sel, w_sel_nxt;
  logic          r_tgt, w_tgt_nxt;
  logic          r_cur, w_cur_nxt;
  logic          r_done, w_done_nxt;
  logic          r_fb, w_fb_nxt;
  logic          r_err, w_err_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          w_lock_ok;
  logic          w_accept;
  logic          w_fall;

  ngmux_lock_qual #(
    .SYNC_STAGES       (SYNC_STAGES),
    .LOCK_STABLE_CYCLES(LOCK_STABLE_CYCLES)
  ) u_lock_qual (
    .i_clk     (i_clk),
    .i_resetn  (i_resetn),
    .i_pll_lock(i_pll_lock),
    .o_lock_ok (w_lock_ok)
  );

  assign w_accept = i_req_valid && (r_state == IDLE);
  // Level form: once SEL/tgt are forced to the reference it cannot retrigger.
  assign w_fall   = !w_lock_ok && (r_sel || r_tgt);

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_state <= IDLE;
      r_sel   <= CLKSEL_REF;
      r_tgt   <= CLKSEL_REF;
      r_cur   <= CLKSEL_REF;
      r_done  <= 1'b0;
      r_fb    <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= w_sel_nxt;
      r_tgt   <= w_tgt_nxt;
      r_cur   <= w_cur_nxt;
      r_done  <= w_done_nxt;
      r_fb    <= w_fb_nxt;
      r_err   <= w_err_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_tgt_nxt   = r_tgt;
    w_cur_nxt   = r_cur;
    w_done_nxt  = 1'b0;
    w_fb_nxt    = r_fb;
    w_err_nxt   = r_err;
    w_cnt_nxt   = r_cnt;
    if (w_fall) begin
      w_sel_nxt   = CLKSEL_REF;
      w_tgt_nxt   = CLKSEL_REF;
      w_fb_nxt    = 1'b1;
      w_cnt_nxt   = c_settle_ld;
      w_state_nxt = SETTLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            w_fb_nxt = 1'b0;
            if (i_req_sel == r_cur) begin
              w_done_nxt = 1'b1;
            end else if ((i_req_sel == CLKSEL_PLL) && !w_lock_ok) begin
              w_err_nxt = 1'b1;
            end else begin
              w_tgt_nxt   = i_req_sel;
              w_cnt_nxt   = '0;
              w_state_nxt = DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!i_core_busy) begin
            w_state_nxt = SWITCH;
          end
`ifdef NGMUX_DRAIN_TIMEOUT_EN
          else if (r_cnt == c_tmo_last) begin
            w_err_nxt   = 1'b1;
            w_tgt_nxt   = r_cur;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
`endif
        end
        SWITCH: begin
          w_sel_nxt   = r_tgt;
          w_cnt_nxt   = c_settle_ld;
          w_state_nxt = SETTLE;
        end
        SETTLE: begin
          if (r_cnt == '0) begin
            w_cur_nxt   = r_tgt;
            w_done_nxt  = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_cnt_nxt = r_cnt - 1'b1;
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  assign o_req_ready   = i_resetn && (r_state == IDLE);
  assign o_core_hold   = (r_state != IDLE);
  assign o_sel         = r_sel;
  assign o_cur_sel     = r_cur;
  assign o_switch_done = r_done;
  assign o_fallback    = r_fb;
  assign o_err         = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ngmux_switch_ctrl.sv
// ============================================================================
// Module      : tb_ngmux_switch_ctrl
// Description : Directed table-driven bench for ngmux_switch_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ngmux_switch_ctrl;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic vld = 1'b0;
  logic rsel = 1'b0;
  logic busy = 1'b0;
  logic lock = 1'b0;
  logic ready, hold, sel, cur, done, fb, err;
  logic [6:0] outs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  ngmux_switch_ctrl #(
    .SETTLE_CYCLES     (16),
    .SYNC_STAGES       (2),
    .LOCK_STABLE_CYCLES(64),
    .TIMEOUT_CYCLES    (1024)
  ) dut (
    .i_clk        (clk),
    .i_resetn     (rstn),
    .i_req_valid  (vld),
    .i_req_sel    (rsel),
    .o_req_ready  (ready),
    .i_core_busy  (busy),
    .o_core_hold  (hold),
    .i_pll_lock   (lock),
    .o_sel        (sel),
    .o_cur_sel    (cur),
    .o_switch_done(done),
    .o_fallback   (fb),
    .o_err        (err)
  );

  // {ready, hold, sel, cur, done, fallback, err}
  assign outs = {ready, hold, sel, cur, done, fb, err};

  typedef struct {
    string      name;
    int         cyc;
    logic [4:0] in;   // {rstn, valid, req_sel, busy, pll_lock}
    logic [6:0] ex;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(string n, int c, logic [4:0] in, logic [6:0] ex);
    vec_t v;
    v.name = n;
    v.cyc  = c;
    v.in   = in;
    v.ex   = ex;
    vecs.push_back(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(string name, logic [6:0] act, logic [6:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%b required=%b (rdy,hold,sel,cur,done,fb,err)", name, act, exp);
    end
  endtask

  initial begin
    //        name            cyc  rvsbl       rhscdfe
    add("rst",             2,  5'b00000, 7'b0000000);
    add("idle",            1,  5'b10000, 7'b1000000);
    add("same_tgt",        1,  5'b11000, 7'b1000100);
    add("same_tgt_end",    1,  5'b10000, 7'b1000000);
    add("reject",          1,  5'b11100, 7'b1000001);
    add("reject_sticky",   3,  5'b10000, 7'b1000001);
    add("lock_wait",      64,  5'b10001, 7'b1000001);
    add("lock_edge_rej",   1,  5'b11101, 7'b1000001);
    add("lock_edge_acc",   1,  5'b11101, 7'b0100001);
    add("drain",           1,  5'b10001, 7'b0100001);
    add("switch",          1,  5'b10001, 7'b0110001);
    add("settle",         15,  5'b10001, 7'b0110001);
    add("done_pll",        1,  5'b10001, 7'b1011101);
    add("post_done",       1,  5'b10001, 7'b1011001);
    add("busy_acc",        1,  5'b11011, 7'b0111001);
    add("busy_hold",      49,  5'b10011, 7'b0111001);
    add("busy_fall",       1,  5'b10001, 7'b0111001);
    add("sel_ref",         1,  5'b10001, 7'b0101001);
    add("settle_ref",     15,  5'b10001, 7'b0101001);
    add("done_ref",        1,  5'b10001, 7'b1000101);
    add("acc_pll2",        1,  5'b11101, 7'b0100001);
    add("done_pll2",      18,  5'b10001, 7'b1011101);
    add("lock_drop",       2,  5'b10000, 7'b1011001);
    add("fallback",        1,  5'b10000, 7'b0101011);
    add("fb_settle",      15,  5'b10000, 7'b0101011);
    add("fb_done",         1,  5'b10000, 7'b1000111);
    add("fb_sticky",       1,  5'b10000, 7'b1000011);
    add("fb_clear",        1,  5'b11000, 7'b1000101);
    add("relock",         65,  5'b10001, 7'b1000001);
    add("acc_pll3",        1,  5'b11101, 7'b0100001);
    add("mid_settle",      5,  5'b10001, 7'b0110001);
    add("rst_mid",         1,  5'b00001, 7'b0000000);
    add("no_pulse",       17,  5'b10001, 7'b1000000);
    add("tmo_lock",       60,  5'b10001, 7'b1000000);
    add("tmo_acc",         1,  5'b11111, 7'b0100000);
    add("tmo_busy",     1023,  5'b10011, 7'b0100000);
`ifdef NGMUX_DRAIN_TIMEOUT_EN
    add("tmo_err",         1,  5'b10011, 7'b1000001);
`else
    add("drain_waits",     1,  5'b10011, 7'b0100000);
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      {rstn, vld, rsel, busy, lock} = vecs[i].in;
      for (int c = 0; c < vecs[i].cyc; c++) tick();
      chk(vecs[i].name, outs, vecs[i].ex);
    end

    // Lock loss in the same cycle as a request acceptance.
    {rstn, vld, rsel, busy, lock} = 5'b00000;
    repeat (2) tick();
    rstn = 1'b1;
    lock = 1'b1;
    repeat (66) tick();
    vld  = 1'b1;
    rsel = 1'b1;
    tick();
    vld  = 1'b0;
    rsel = 1'b0;
    repeat (18) tick();
    chk("hs_on_pll", outs, 7'b1011100);
    lock = 1'b0;
    repeat (2) tick();
    vld  = 1'b1;
    rsel = 1'b1;
    tick();
    vld  = 1'b0;
    rsel = 1'b0;
    chk("hs_accept_fall", outs, 7'b0101010);
    repeat (15) tick();
    chk("hs_fb_settle", outs, 7'b0101010);
    tick();
    chk("hs_fb_done", outs, 7'b1000110);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
